rob_param: RTL
==============

Name: rob_param

Overview:
- Parametrised next-generation reorder buffer: in-order allocation at dispatch, out-of-order completion from the CDB, in-order retirement to R-RAT/PRF.
- Generalises dispatch width, CDB lane count, retire width and depth.
- Adds wrap-around retirement, a credit-style ready output and mispredict flush.
- Sits between ID/rename (allocation, robid return to F-RAT) and the R-RAT/PRF retire path.

Parameters:
ROB_SIZE, 32, entry count; power of 2, >= 2*DISP_WIDTH
DISP_WIDTH, 2, instructions allocated per cycle
CDB_LANES, 3, completion lanes
RET_WIDTH, 4, max retirements per cycle; <= ROB_SIZE
DATA_LEN, 32, result/PC width
PTR_W, $clog2(ROB_SIZE), entry index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
disp_val  in  DISP_WIDTH  dispatch valid per lane; lower-packed (lane i valid implies lanes <i valid)
disp_pc  in  DISP_WIDTH*DATA_LEN  instruction PC
disp_rd  in  DISP_WIDTH*5  architectural destination
disp_op  in  DISP_WIDTH*7  opcode
disp_rdy  out  1  free entries >= DISP_WIDTH and no flush pending
disp_robid  out  DISP_WIDTH*PTR_W  robid assigned to each lane (tail+i), combinational
cdb_val  in  CDB_LANES  completion valid
cdb_robid  in  CDB_LANES*PTR_W  completing entry
cdb_result  in  CDB_LANES*DATA_LEN  result data
cdb_mispred  in  CDB_LANES  branch resolved mispredicted
cdb_tgt  in  CDB_LANES*DATA_LEN  correct branch target
ret_val  out  RET_WIDTH  retire valid, lower-packed
ret_rd  out  RET_WIDTH*5  retiring destination
ret_data  out  RET_WIDTH*DATA_LEN  retiring result
ret_pc  out  RET_WIDTH*DATA_LEN  retiring PC
ret_ptr  out  PTR_W  head index after this cycle's retirement (to R-RAT)
flush_val  out  1  one-cycle pulse: pipeline flush
flush_pc  out  DATA_LEN  redirect target
rob_count  out  PTR_W+1  occupied entries

Behaviour:
- Pointers: head/tail are PTR_W+1 bits; the extra bit is the wrap bit. Empty: head==tail. Full: indices equal, wrap bits differ. rob_count = tail-head (mod 2^(PTR_W+1)).
- Reset (async, rst_n low): head=tail=0, all entries v=0/done=0/mispred=0; ret_val=0, ret_rd/ret_data/ret_pc=0, flush_val=0, flush_pc=0. Reset mid-operation discards all contents; no retire pulses follow.
- Allocate: when disp_rdy=1, each valid lane i writes entry tail+i (mod ROB_SIZE) with v=1, done=0, mispred=0. tail advances by popcount(disp_val). disp_val while disp_rdy=0 is ignored; upstream must hold.
- Complete: cdb_val[k] on a valid entry sets done=1 and latches result, mispred and tgt. Writes to invalid entries are dropped. Two lanes naming the same robid in one cycle is illegal.
- Retire count n: the leading run of done entries from head, capped at RET_WIDTH and rob_count. The run crosses the ROB_SIZE-1 to 0 boundary without restriction. Run stops after the first mispred entry; that entry retires.
- Retire outputs are registered with 1-cycle latency: slot j carries entry head+j in the cycle after selection. Retired entries are cleared (v=0, done=0). head += n.
- A CDB write and a retire-scan of the same entry in the same cycle: the scan sees the old done=0; the entry retires no earlier than the next cycle.
- Flush: when a mispred entry retires, in the same edge set tail=new head and clear all v/done. flush_val=1 and flush_pc=tgt are registered alongside that entry's ret_val. disp_rdy=0 during the flush cycle. Dispatch and CDB inputs in the flush-selection cycle are discarded.
- Full plus retire in the same cycle: disp_rdy uses the pre-retire count (conservative). No bypass.

Test Plan:
- Reset then dispatch 2/cycle for 16 cycles, no CDB -> rob_count=32, disp_rdy=0 from rob_count=31; robids 0..31 in order.
- Fill 32, complete all in reverse robid order -> nothing retires until robid 0 completes, then 4/cycle; ret_pc ascending; 8 retire cycles.
- head=30, entries 30,31,0,1 done -> one cycle with ret_val=4'b1111, ret_ptr=2, wrap bit toggled.
- Entries 5..9 done, 7 mispred tgt=0x100 -> ret_val=4'b0111 (5,6,7); flush_val=1, flush_pc=0x100; next cycle rob_count=0, disp_rdy=1.
- CDB completes head entry in the same cycle the scan reaches it -> ret_val=0 that cycle; retires the following cycle.
- Assert rst_n low mid-fill (rob_count=12) -> outputs zero immediately; after release, first disp_robid=0.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocation, out-of-order completion from the CDB,
// in-order multi-wide retirement with wrap-around and mispredict flush.
module rob_param #(
    parameter int unsigned ROB_SIZE   = 32,
    parameter int unsigned DISP_WIDTH = 2,
    parameter int unsigned CDB_LANES  = 3,
    parameter int unsigned RET_WIDTH  = 4,
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned PTR_W      = $clog2(ROB_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DISP_WIDTH-1:0]          disp_val,
    input  logic [DISP_WIDTH*DATA_LEN-1:0] disp_pc,
    input  logic [DISP_WIDTH*5-1:0]        disp_rd,
    input  logic [DISP_WIDTH*7-1:0]        disp_op,
    output logic                           disp_rdy,
    output logic [DISP_WIDTH*PTR_W-1:0]    disp_robid,
    input  logic [CDB_LANES-1:0]           cdb_val,
    input  logic [CDB_LANES*PTR_W-1:0]     cdb_robid,
    input  logic [CDB_LANES*DATA_LEN-1:0]  cdb_result,
    input  logic [CDB_LANES-1:0]           cdb_mispred,
    input  logic [CDB_LANES*DATA_LEN-1:0]  cdb_tgt,
    output logic [RET_WIDTH-1:0]           ret_val,
    output logic [RET_WIDTH*5-1:0]         ret_rd,
    output logic [RET_WIDTH*DATA_LEN-1:0]  ret_data,
    output logic [RET_WIDTH*DATA_LEN-1:0]  ret_pc,
    output logic [PTR_W-1:0]               ret_ptr,
    output logic                           flush_val,
    output logic [DATA_LEN-1:0]            flush_pc,
    output logic [PTR_W:0]                 rob_count
);
    logic [PTR_W:0]        head, tail, count, free_cnt, disp_cnt, ret_n, head_nxt;
    logic [ROB_SIZE-1:0]   e_v, e_done, e_mis;
    logic [DATA_LEN-1:0]   e_pc  [ROB_SIZE];
    logic [DATA_LEN-1:0]   e_res [ROB_SIZE];
    logic [DATA_LEN-1:0]   e_tgt [ROB_SIZE];
    logic [4:0]            e_rd  [ROB_SIZE];
    logic [PTR_W-1:0]      alloc_idx [DISP_WIDTH];
    logic [PTR_W-1:0]      cdb_idx   [CDB_LANES];
    logic [PTR_W-1:0]      scan_idx  [RET_WIDTH];
    logic [RET_WIDTH-1:0]  ret_sel;
    logic                  scan_stop, flush_sel, alloc_fire;
    logic [DATA_LEN-1:0]   flush_tgt;
    logic                  unused_op;

    assign count     = tail - head;
    assign free_cnt  = (PTR_W+1)'(ROB_SIZE) - count;
    assign rob_count = count;
    assign ret_ptr   = head[PTR_W-1:0];
    // Opcode is not needed for retirement bookkeeping
    assign unused_op = ^disp_op;

    always_comb begin
        disp_cnt   = '0;
        disp_robid = '0;
        alloc_idx  = '{default: '0};
        cdb_idx    = '{default: '0};
        for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
            alloc_idx[i] = tail[PTR_W-1:0] + PTR_W'(i);
            disp_robid[i*PTR_W +: PTR_W] = alloc_idx[i];
            disp_cnt = disp_cnt + (PTR_W+1)'(disp_val[i]);
        end
        for (int unsigned k = 0; k < CDB_LANES; k++) begin
            cdb_idx[k] = cdb_robid[k*PTR_W +: PTR_W];
        end
    end

    // Leading run of done entries from head; a mispredicted entry retires and ends the run
    always_comb begin
        ret_sel   = '0;
        ret_n     = '0;
        scan_stop = 1'b0;
        flush_sel = 1'b0;
        flush_tgt = '0;
        scan_idx  = '{default: '0};
        for (int unsigned j = 0; j < RET_WIDTH; j++) begin
            scan_idx[j] = head[PTR_W-1:0] + PTR_W'(j);
            if (!scan_stop && ((PTR_W+1)'(j) < count) &&
                e_v[scan_idx[j]] && e_done[scan_idx[j]]) begin
                ret_sel[j] = 1'b1;
                ret_n      = (PTR_W+1)'(j + 1);
                if (e_mis[scan_idx[j]]) begin
                    scan_stop = 1'b1;
                    flush_sel = 1'b1;
                    flush_tgt = e_tgt[scan_idx[j]];
                end
            end else begin
                scan_stop = 1'b1;
            end
        end
        head_nxt   = head + ret_n;
        disp_rdy   = (free_cnt >= (PTR_W+1)'(DISP_WIDTH)) && !flush_sel;
        alloc_fire = disp_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            e_v       <= '0;
            e_done    <= '0;
            e_mis     <= '0;
            ret_val   <= '0;
            ret_rd    <= '0;
            ret_data  <= '0;
            ret_pc    <= '0;
            flush_val <= 1'b0;
            flush_pc  <= '0;
        end else begin
            ret_val   <= ret_sel;
            flush_val <= flush_sel;
            flush_pc  <= flush_tgt;
            for (int unsigned j = 0; j < RET_WIDTH; j++) begin
                ret_rd[j*5 +: 5]               <= ret_sel[j] ? e_rd[scan_idx[j]]  : '0;
                ret_data[j*DATA_LEN +: DATA_LEN] <= ret_sel[j] ? e_res[scan_idx[j]] : '0;
                ret_pc[j*DATA_LEN +: DATA_LEN]   <= ret_sel[j] ? e_pc[scan_idx[j]]  : '0;
            end
            head <= head_nxt;
            if (flush_sel) begin
                tail   <= head_nxt;
                e_v    <= '0;
                e_done <= '0;
                e_mis  <= '0;
            end else begin
                if (alloc_fire) tail <= tail + disp_cnt;
                for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
                    if (alloc_fire && disp_val[i]) begin
                        e_v[alloc_idx[i]]    <= 1'b1;
                        e_done[alloc_idx[i]] <= 1'b0;
                        e_mis[alloc_idx[i]]  <= 1'b0;
                    end
                end
                for (int unsigned k = 0; k < CDB_LANES; k++) begin
                    if (cdb_val[k] && e_v[cdb_idx[k]]) begin
                        e_done[cdb_idx[k]] <= 1'b1;
                        e_mis[cdb_idx[k]]  <= cdb_mispred[k];
                    end
                end
                // Retire clears last so a stale completion cannot revive a retired entry
                for (int unsigned j = 0; j < RET_WIDTH; j++) begin
                    if (ret_sel[j]) begin
                        e_v[scan_idx[j]]    <= 1'b0;
                        e_done[scan_idx[j]] <= 1'b0;
                        e_mis[scan_idx[j]]  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
            if (alloc_fire && disp_val[i]) begin
                e_pc[alloc_idx[i]] <= disp_pc[i*DATA_LEN +: DATA_LEN];
                e_rd[alloc_idx[i]] <= disp_rd[i*5 +: 5];
            end
        end
        for (int unsigned k = 0; k < CDB_LANES; k++) begin
            if (!flush_sel && cdb_val[k] && e_v[cdb_idx[k]]) begin
                e_res[cdb_idx[k]] <= cdb_result[k*DATA_LEN +: DATA_LEN];
                e_tgt[cdb_idx[k]] <= cdb_tgt[k*DATA_LEN +: DATA_LEN];
            end
        end
    end

endmodule
